inst_mem_responder: RTL
=======================

INST_MEM_RESPONDER -- requirements
Module: inst_mem_responder

Interface
REQ-001 Parameter PC_DATA_WIDTH, default 20, SHALL set the fetch address width.
REQ-002 Parameter INST_DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter MEM_ADDR_BITS, default 10, SHALL set the word-address width, giving a depth of 2^MEM_ADDR_BITS words.
REQ-004 Parameter NOP_INST, default 32'h0000_0000, SHALL set the word returned whenever no valid read occurs.
REQ-005 clk  input  1  SHALL be the core clock; all state SHALL update on its rising edge.
REQ-006 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-007 inst_mem_addr_in  input  PC_DATA_WIDTH  SHALL carry the byte address of the fetch.
REQ-008 inst_mem_data_out  output  INST_DATA_WIDTH  SHALL carry the registered instruction word.
REQ-009 core_stall_out  output  1  SHALL be high whenever the state is not RUN.
REQ-010 addr_error_out  output  1  SHALL be a registered one-cycle flag marking a rejected fetch.
REQ-011 load_start_in  input  1  SHALL request the start of a program load.
REQ-012 load_byte_in  input  8  SHALL carry the program byte being loaded.
REQ-013 load_valid_in  input  1  SHALL qualify load_byte_in.
REQ-014 load_last_in  input  1  SHALL mark the final byte of the load; it is sampled only with an accepted byte.
REQ-015 load_ready_out  output  1  SHALL be high only in state LOAD.
REQ-016 load_count_out  output  MEM_ADDR_BITS+1  SHALL give the number of words written since the last load_start_in, saturating at 2^MEM_ADDR_BITS.
REQ-017 load_overflow_out  output  1  SHALL be a sticky flag set when the write address wraps.

Function
REQ-018 The FSM SHALL have three states: IDLE, LOAD and RUN.
REQ-019 Transitions: IDLE->LOAD on load_start_in; RUN->LOAD on load_start_in; LOAD->RUN on an accepted byte with load_last_in=1. No other transitions SHALL exist.
REQ-020 load_start_in SHALL be ignored while in LOAD.
REQ-021 Entry to LOAD SHALL clear the write address, the byte counter, load_count_out and load_overflow_out.
REQ-022 A byte SHALL be accepted when load_valid_in and load_ready_out are both high.
REQ-023 Bytes SHALL be assembled big-endian: the first byte fills bits [31:24] and the fourth fills bits [7:0].
REQ-024 On the 4th byte, the assembled word SHALL be written to mem[wr_addr], wr_addr SHALL increment, and load_count_out SHALL increment; the write occurs in the same edge that accepts the byte.
REQ-025 If load_last_in arrives on byte 1, 2 or 3 of a word, the unfilled low bytes SHALL be zero, the partial word SHALL be written, and the byte counter SHALL clear.
REQ-026 When wr_addr increments past 2^MEM_ADDR_BITS-1 it SHALL wrap to 0, set load_overflow_out, and let subsequent writes overwrite earlier words.
REQ-027 In RUN, a valid fetch SHALL update inst_mem_data_out on the next edge to mem[inst_mem_addr_in[MEM_ADDR_BITS+1:2]], giving 1-cycle latency.
REQ-028 A fetch in RUN is rejected if inst_mem_addr_in[1:0] != 0 or any address bit at or above MEM_ADDR_BITS+2 is set.
REQ-029 A rejected fetch SHALL give inst_mem_data_out = NOP_INST and addr_error_out = 1 on the next edge.
REQ-030 In IDLE and LOAD, inst_mem_data_out SHALL be NOP_INST on every edge and addr_error_out SHALL be 0.
REQ-031 core_stall_out SHALL be combinational from the state register.
REQ-032 The write port and read port SHALL be independent.
REQ-033 Reads in the RUN cycle immediately after LOAD SHALL see all words written during the load.

Reset
REQ-034 While rst_n=0 the block SHALL hold: state IDLE, inst_mem_data_out = NOP_INST, addr_error_out = 0, load_count_out = 0, load_overflow_out = 0, byte counter = 0, write address = 0, load_ready_out = 0, core_stall_out = 1.
REQ-035 The memory array SHALL NOT be reset; an assertion of reset during LOAD SHALL abandon the partial word and leave already-written words intact.

Verification
REQ-036 Reset, then load_start, then 8 bytes 11..88 with last on the 8th -> mem[0]=32'h11223344, mem[1]=32'h55667788, load_count_out=2, state RUN.
REQ-037 In RUN, fetch address 0x4 -> inst_mem_data_out=32'h55667788 exactly one edge later, addr_error_out=0, core_stall_out=0.
REQ-038 Fetch address 0x6, then address 0x01000 with MEM_ADDR_BITS=10 -> each yields NOP_INST and a one-cycle addr_error_out pulse.
REQ-039 Load 5 bytes AA,BB,CC,DD,EE with last on the 5th -> mem[1]=32'hEE000000, load_count_out=2.
REQ-040 With MEM_ADDR_BITS=2, load 5 words -> load_overflow_out=1, mem[0] holds the 5th word, load_count_out=4 (saturated).
REQ-041 Assert reset after 2 bytes of a load -> IDLE, core_stall_out=1, data NOP_INST, prior words intact; a load_start pulse while in LOAD is ignored.

Source files
------------

// File: rtl/inst_mem_responder_if.sv
// inst_mem_responder_if: fetch and program-load signals between a core/loader and the instruction memory responder.
interface inst_mem_responder_if #(
  parameter int PC_DATA_WIDTH   = 20,
  parameter int INST_DATA_WIDTH = 32,
  parameter int MEM_ADDR_BITS   = 10
);
  logic [PC_DATA_WIDTH-1:0]   inst_mem_addr_in;
  logic [INST_DATA_WIDTH-1:0] inst_mem_data_out;
  logic                       core_stall_out;
  logic                       addr_error_out;
  logic                       load_start_in;
  logic [7:0]                 load_byte_in;
  logic                       load_valid_in;
  logic                       load_last_in;
  logic                       load_ready_out;
  logic [MEM_ADDR_BITS:0]     load_count_out;
  logic                       load_overflow_out;

  modport slave (
    input  inst_mem_addr_in, load_start_in, load_byte_in, load_valid_in, load_last_in,
    output inst_mem_data_out, core_stall_out, addr_error_out, load_ready_out,
           load_count_out, load_overflow_out
  );

  modport master (
    output inst_mem_addr_in, load_start_in, load_byte_in, load_valid_in, load_last_in,
    input  inst_mem_data_out, core_stall_out, addr_error_out, load_ready_out,
           load_count_out, load_overflow_out
  );
endinterface

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory loaded big-endian byte by byte, then served to the core with 1-cycle fetch latency.
module inst_mem_responder #(
  parameter int                       PC_DATA_WIDTH   = 20,
  parameter int                       INST_DATA_WIDTH = 32,
  parameter int                       MEM_ADDR_BITS   = 10,
  parameter logic [INST_DATA_WIDTH-1:0] NOP_INST      = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  inst_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  localparam logic [MEM_ADDR_BITS:0] FULL = (MEM_ADDR_BITS+1)'(1) << MEM_ADDR_BITS;

  state_t                     r_state, w_next;
  logic [INST_DATA_WIDTH-1:0] r_mem [2**MEM_ADDR_BITS];
  logic [MEM_ADDR_BITS-1:0]   r_wr_addr;
  logic [1:0]                 r_byte_cnt;
  logic [INST_DATA_WIDTH-1:0] r_buf, r_data;
  logic [MEM_ADDR_BITS:0]     r_count;
  logic                       r_ovf, r_err;
  logic                       w_accept, w_write, w_enter, w_bad;
  logic [INST_DATA_WIDTH-1:0] w_word;

  assign w_enter  = r_state != LOAD && bus.load_start_in;
  assign w_accept = r_state == LOAD && bus.load_valid_in;
  assign w_write  = w_accept && (r_byte_cnt == 2'd3 || bus.load_last_in);
  // First byte lands in the top byte lane; unfilled lanes stay zero from the cleared buffer.
  assign w_word   = r_buf | (INST_DATA_WIDTH'(bus.load_byte_in) << (5'(INST_DATA_WIDTH - 8) - {r_byte_cnt, 3'b000}));
  assign w_bad    = |bus.inst_mem_addr_in[1:0] || |(bus.inst_mem_addr_in >> (MEM_ADDR_BITS + 2));

  always_comb begin
    w_next = w_enter ? LOAD : (w_accept && bus.load_last_in) ? RUN : r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wr_addr  <= '0;
      r_byte_cnt <= '0;
      r_buf      <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_data     <= NOP_INST;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter) begin
        r_wr_addr  <= '0;
        r_byte_cnt <= '0;
        r_buf      <= '0;
        r_count    <= '0;
        r_ovf      <= 1'b0;
      end else if (w_accept) begin
        r_byte_cnt <= w_write ? 2'd0 : r_byte_cnt + 2'd1;
        r_buf      <= w_write ? '0 : w_word;
        if (w_write) begin
          r_wr_addr <= r_wr_addr + MEM_ADDR_BITS'(1);
          if (&r_wr_addr) r_ovf <= 1'b1;
          if (r_count != FULL) r_count <= r_count + (MEM_ADDR_BITS+1)'(1);
        end
      end
      r_data <= (r_state == RUN && !w_bad) ? r_mem[bus.inst_mem_addr_in[MEM_ADDR_BITS+1:2]] : NOP_INST;
      r_err  <= r_state == RUN && w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_addr] <= w_word;
  end

  assign bus.inst_mem_data_out = r_data;
  assign bus.addr_error_out    = r_err;
  assign bus.core_stall_out    = r_state != RUN;
  assign bus.load_ready_out    = r_state == LOAD;
  assign bus.load_count_out    = r_count;
  assign bus.load_overflow_out = r_ovf;
endmodule
